// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared types and constants for the TMDS 8b/10b channel encoder.
//   tmds_sym_t   : one 10-bit TMDS symbol, LSB transmitted first
//   CTRL_SYM_xx  : the four control-period symbols, indexed by {C1,C0}
//   RESET_SYM    : the symbol driven while the encoder is held in reset
//   TERC4_SYMS   : data-island TERC4 codes for nibbles 0..F (used only when
//                  the encoder is built with TMDS_TERC4_EN)
//   ctrl_symbol(): maps {C1,C0} to its control symbol
//   popcount8()  : number of ones in a byte, as a 4-bit count
// -----------------------------------------------------------------------------
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_SYM_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_SYM_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_SYM_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_SYM_11 = 10'b1010101011;

  // Reset looks exactly like a blanking period with both control bits low.
  localparam tmds_sym_t RESET_SYM = CTRL_SYM_00;

  localparam tmds_sym_t TERC4_SYMS [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic tmds_sym_t ctrl_symbol(input logic [1:0] ctrl);
    tmds_sym_t sym;
    case (ctrl)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_balance.sv
// -----------------------------------------------------------------------------
// tmds_balance
// Second pipeline stage of the TMDS encoder: keeps the running disparity and
// picks whether to send the transition-minimised word straight or inverted so
// the line stays DC balanced. During blanking/island periods it passes the
// symbol chosen upstream and clears the disparity.
//   clk_pix    in   pixel clock, rising edge
//   rst_pix    in   synchronous active-high reset
//   data_valid in   staged data enable (1 = video word in q_m)
//   q_m        in   9-bit transition-minimised word from stage 1
//   alt_sym    in   control or TERC4 symbol used when data_valid is 0
//   tmds       out  registered 10-bit symbol
// -----------------------------------------------------------------------------
module tmds_balance
  import tmds_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       data_valid,
  input  logic [8:0] q_m,
  input  tmds_sym_t  alt_sym,
  output tmds_sym_t  tmds
);

  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  tmds_sym_t         sym_next;
  logic [3:0]        n1q;
  logic [3:0]        n0q;
  logic signed [4:0] diff;
  logic signed [4:0] two_q8;
  logic signed [4:0] two_nq8;

  assign n1q     = popcount8(q_m[7:0]);
  assign n0q     = 4'd8 - n1q;
  // Counts are zero-extended to 5 bits before subtracting so the ones-minus-
  // zeros imbalance is a proper signed value in -8..+8.
  assign diff    = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
  assign two_q8  = $signed({3'b000, q_m[8], 1'b0});
  assign two_nq8 = $signed({3'b000, ~q_m[8], 1'b0});

  // Choose between the three balancing cases. A neutral disparity or a
  // balanced word keeps the natural polarity (inverting only XNOR words);
  // otherwise invert when the word would push disparity further the same way.
  always_comb begin
    sym_next = alt_sym;
    cnt_next = 5'sd0;
    if (data_valid) begin
      if (cnt == 5'sd0 || n1q == n0q) begin
        sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[4] && n1q > n0q) || (cnt[4] && n0q > n1q)) begin
        sym_next = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_next = cnt + two_q8 - diff;
      end else begin
        sym_next = {1'b0, q_m[8], q_m[7:0]};
        cnt_next = cnt - two_nq8 + diff;
      end
    end
  end

  // Output symbol and disparity register. Reset leaves the line in the
  // control-00 state with zero disparity.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cnt  <= 5'sd0;
      tmds <= RESET_SYM;
    end else begin
      cnt  <= cnt_next;
      tmds <= sym_next;
    end
  end

endmodule

// File: rtl/tmds_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tmds_encoder_pipe
// Two-stage pipelined TMDS 8b/10b encoder for one DVI/HDMI colour channel.
// Stage 1 does transition minimisation and stages the control inputs; stage 2
// (tmds_balance) does DC balancing and registers the output symbol.
// Latency is two clocks, one symbol per clock, no handshake.
//   clk_pix   in   pixel clock, rising edge
//   rst_pix   in   synchronous active-high reset
//   de        in   data enable: 1 = video data, 0 = control/island
//   data_in   in   pixel byte (used when de=1)
//   ctrl_in   in   {C1,C0} control bits (used when de=0)
//   island_in in   data-island period (TMDS_TERC4_EN builds only)
//   terc4_in  in   TERC4 nibble (TMDS_TERC4_EN builds only)
//   tmds      out  10-bit symbol, LSB transmitted first
// Build option: define TMDS_TERC4_EN to add TERC4 data-island encoding; without
// it island_in and terc4_in are ignored.
// -----------------------------------------------------------------------------
module tmds_encoder_pipe
  import tmds_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       de,
  input  logic [7:0] data_in,
  input  logic [1:0] ctrl_in,
  input  logic       island_in,
  input  logic [3:0] terc4_in,
  output logic [9:0] tmds
);

  // XNOR chaining is used for bytes with many ones so the encoded word has
  // fewer transitions; q_m[8] records which chain was used (1 = XOR).
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0] q_m_s1;
  logic       de_s1;
  logic [1:0] ctrl_s1;
  tmds_sym_t  alt_sym;

`ifdef TMDS_TERC4_EN
  logic       island_s1;
  logic [3:0] terc4_s1;

  // Stage 1 register. Reset loads the control-00 state so the output settles
  // on the reset symbol until real input has passed through both stages.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      q_m_s1    <= 9'd0;
      de_s1     <= 1'b0;
      ctrl_s1   <= 2'b00;
      island_s1 <= 1'b0;
      terc4_s1  <= 4'd0;
    end else begin
      q_m_s1    <= minimise(data_in);
      de_s1     <= de;
      ctrl_s1   <= ctrl_in;
      island_s1 <= island_in;
      terc4_s1  <= terc4_in;
    end
  end

  // Non-video symbol: TERC4 during data islands, control code otherwise.
  // Video always wins because stage 2 only uses this when de_s1 is low.
  always_comb begin
    alt_sym = ctrl_symbol(ctrl_s1);
    if (island_s1) begin
      alt_sym = TERC4_SYMS[terc4_s1];
    end
  end
`else
  logic unused_terc4;
  assign unused_terc4 = ^{island_in, terc4_in};

  // Stage 1 register. Reset loads the control-00 state so the output settles
  // on the reset symbol until real input has passed through both stages.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      q_m_s1  <= 9'd0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
    end else begin
      q_m_s1  <= minimise(data_in);
      de_s1   <= de;
      ctrl_s1 <= ctrl_in;
    end
  end

  // Non-video symbol is always the control code in this build.
  always_comb begin
    alt_sym = ctrl_symbol(ctrl_s1);
  end
`endif

  tmds_balance u_balance (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .data_valid (de_s1),
    .q_m        (q_m_s1),
    .alt_sym    (alt_sym),
    .tmds       (tmds)
  );

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder_pipe
// Self-checking bench for tmds_encoder_pipe: a directed vector table with
// hand-computed symbols, hand-written reset and (with TMDS_TERC4_EN) island
// sequences, and a randomized stream checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_tmds_encoder_pipe;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic       de;
  logic [7:0] data_in;
  logic [1:0] ctrl_in;
  logic       island_in;
  logic [3:0] terc4_in;
  logic [9:0] tmds;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       island;
    logic [3:0] terc4;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [9:0] exp;
  } vec_t;

  tmds_encoder_pipe dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .de        (de),
    .data_in   (data_in),
    .ctrl_in   (ctrl_in),
    .island_in (island_in),
    .terc4_in  (terc4_in),
    .tmds      (tmds)
  );

  always #5 clk_pix = ~clk_pix;

  // Reference values written out independently of the design package.
  logic [9:0] ref_ctrl  [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] ref_terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Behavioural model: one input waits in flight, the line disparity is an int.
  in_t model_pend;
  int  model_disp = 0;

  function automatic in_t mk(input logic rst, input logic d_en, input logic [7:0] d,
                             input logic [1:0] c, input logic isl, input logic [3:0] t);
    in_t s;
    s.rst = rst; s.de = d_en; s.data = d; s.ctrl = c; s.island = isl; s.terc4 = t;
    return s;
  endfunction

  // Encode one staged input per the TMDS rules, updating the disparity.
  task automatic model_encode(input in_t s, output logic [9:0] sym);
    int         ones_in, ones, zeros;
    bit         use_xnor, invert;
    logic [7:0] q;
    logic       q8;
    if (!s.de) begin
      model_disp = 0;
      sym = ref_ctrl[s.ctrl];
`ifdef TMDS_TERC4_EN
      if (s.island) sym = ref_terc4[s.terc4];
`endif
      return;
    end
    ones_in  = $countones(s.data);
    use_xnor = (ones_in > 4) || (ones_in == 4 && s.data[0] == 1'b0);
    q[0] = s.data[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? !(q[i-1] ^ s.data[i]) : (q[i-1] ^ s.data[i]);
    q8    = !use_xnor;
    ones  = $countones(q);
    zeros = 8 - ones;
    if (model_disp == 0 || ones == zeros) begin
      invert     = !q8;
      model_disp = model_disp + (q8 ? (ones - zeros) : (zeros - ones));
    end else if ((model_disp > 0 && ones > zeros) || (model_disp < 0 && zeros > ones)) begin
      invert     = 1'b1;
      model_disp = model_disp + 2 * int'(q8) + zeros - ones;
    end else begin
      invert     = 1'b0;
      model_disp = model_disp - 2 * int'(!q8) + ones - zeros;
    end
    sym = {invert, q8, invert ? ~q : q};
  endtask

  // Advance the model by one clock edge that sampled input s.
  task automatic model_edge(input in_t s, output logic [9:0] exp);
    if (s.rst) begin
      exp        = 10'h354;
      model_disp = 0;
      model_pend = mk(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    end else begin
      model_encode(model_pend, exp);
      model_pend = s;
    end
  endtask

  // Drive one cycle of inputs on the falling edge, let the rising edge take
  // them, update the model, and leave the caller 1 time unit after the edge.
  task automatic applyStimulus(input in_t s, output logic [9:0] model_exp);
    @(negedge clk_pix);
    rst_pix   = s.rst;
    de        = s.de;
    data_in   = s.data;
    ctrl_in   = s.ctrl;
    island_in = s.island;
    terc4_in  = s.terc4;
    @(posedge clk_pix);
    model_edge(s, model_exp);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] exp);
    compared++;
    if (tmds !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: tmds=%h expected=%h", name, tmds, exp);
    end
  endtask

  vec_t       vecs [20];
  logic [9:0] mexp;
  in_t        s;
  logic       cur_de;

  initial begin
    rst_pix = 1'b1; de = 1'b0; data_in = 8'h00; ctrl_in = 2'b00;
    island_in = 1'b0; terc4_in = 4'h0;
    model_pend = mk(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);

    // Each row: inputs for this cycle, symbol expected right after its edge
    // (which reflects the input applied one row earlier).
    vecs[0]  = '{mk(1, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[1]  = '{mk(1, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[2]  = '{mk(1, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[3]  = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[4]  = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[5]  = '{mk(0, 0, 8'h00, 2'b01, 0, 0), 10'h354};
    vecs[6]  = '{mk(0, 0, 8'h00, 2'b10, 0, 0), 10'h0AB};
    vecs[7]  = '{mk(0, 0, 8'h00, 2'b11, 0, 0), 10'h154};
    vecs[8]  = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h2AB};
    vecs[9]  = '{mk(0, 1, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[10] = '{mk(0, 1, 8'h00, 2'b00, 0, 0), 10'h100};
    vecs[11] = '{mk(0, 1, 8'h00, 2'b00, 0, 0), 10'h3FF};
    vecs[12] = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h100};
    vecs[13] = '{mk(0, 1, 8'hFF, 2'b00, 0, 0), 10'h354};
    vecs[14] = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h200};
    vecs[15] = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h354};
    vecs[16] = '{mk(0, 1, 8'h1E, 2'b00, 0, 0), 10'h354};
    vecs[17] = '{mk(0, 1, 8'h0F, 2'b00, 0, 0), 10'h25F};
    vecs[18] = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h105};
    vecs[19] = '{mk(0, 0, 8'h00, 2'b00, 0, 0), 10'h354};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stim, mexp);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mid-stream reset: random video, a one-cycle reset pulse, then the
    // stream must restart from zero disparity.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk(0, 1, 8'($urandom), 2'b00, 0, 0), mexp);
      checkOutput($sformatf("pre_rst%0d", i), mexp);
    end
    applyStimulus(mk(1, 1, 8'($urandom), 2'b00, 0, 0), mexp);
    checkOutput("midrst_pulse", 10'h354);
    applyStimulus(mk(0, 1, 8'h00, 2'b00, 0, 0), mexp);
    checkOutput("midrst_hold", 10'h354);
    applyStimulus(mk(0, 1, 8'($urandom), 2'b00, 0, 0), mexp);
    checkOutput("midrst_first", 10'h100);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(0, 1, 8'($urandom), 2'b00, 0, 0), mexp);
      checkOutput($sformatf("post_rst%0d", i), mexp);
    end

`ifdef TMDS_TERC4_EN
    // Island nibbles 0..F, then video that must start from zero disparity.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) s = mk(0, 0, 8'h00, 2'b00, 1, 4'(i));
      else        s = mk(0, 1, 8'h00, 2'b00, 0, 0);
      applyStimulus(s, mexp);
      if (i >= 1 && i <= 16) checkOutput($sformatf("terc4_%0d", i - 1), ref_terc4[i - 1]);
      else if (i == 17)      checkOutput("terc4_then_data", 10'h100);
    end
`else
    // Island inputs must have no effect in this build.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(0, 0, 8'h00, 2'(i), 1, 4'($urandom)), mexp);
      if (i >= 1) checkOutput($sformatf("island_ignored%0d", i), ref_ctrl[(i - 1) % 4]);
    end
`endif

    // Randomized stream with runs of video/blanking and rare reset pulses.
    cur_de = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) cur_de = ~cur_de;
      s = mk(($urandom_range(0, 79) == 0), cur_de, 8'($urandom), 2'($urandom),
             1'($urandom), 4'($urandom));
      applyStimulus(s, mexp);
      checkOutput($sformatf("rand%0d", i), mexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_pipe.md
# tmds_encoder_pipe

Pipelined TMDS 8b/10b symbol encoder for one DVI/HDMI colour channel in the pixel-clock domain. It sits directly upstream of the 10:1 output serializer: it takes a pixel byte, two control bits and data enable each cycle, and emits one DC-balanced 10-bit symbol per cycle. Running disparity is tracked internally. Three instances, one per channel, feed the serializer wrapper.

## Interface
- No parameters; symbol width is fixed at 10 bits and data width at 8 bits.
- clk_pix  in  1  pixel clock; all logic is on the rising edge.
- rst_pix  in  1  synchronous, active-high reset.
- de  in  1  data enable: 1 encodes video data, 0 encodes control.
- data_in  in  8  pixel byte; sampled only when de=1.
- ctrl_in  in  2  control bits {C1,C0}; sampled when de=0.
- island_in  in  1  data-island period; used only with TMDS_TERC4_EN.
- terc4_in  in  4  TERC4 nibble; used only with TMDS_TERC4_EN.
- tmds  out  10  encoded symbol, LSB transmitted first.

## Operation
- Stage 1 (transition minimisation):
  - N1 = popcount(data_in).
  - If N1>4, or N1==4 with data_in[0]==0, use XNOR: q_m[0]=d[0], q_m[i]=~(q_m[i-1]^d[i]), q_m[8]=0.
  - Otherwise use XOR: q_m[i]=q_m[i-1]^d[i], q_m[8]=1.
  - de, ctrl_in, island_in and terc4_in are registered alongside q_m.
- Stage 2 (DC balance). cnt is a signed 5-bit running disparity. N1q/N0q are the ones/zeros counts of q_m[7:0].
  - Case A, cnt==0 or N1q==N0q:
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1q−N0q) : (N0q−N1q).
  - Case B, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - tmds = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + N0q − N1q.
  - Case C, otherwise:
    - tmds = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·(~q_m[8]) + N1q − N0q.
- Control (staged de=0):
  - ctrl 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - cnt is forced to 0.
- Width rules: counts are 4-bit unsigned, extended before subtraction. cnt never leaves −8..+8, so 5-bit signed arithmetic cannot overflow.

## Timing
- Latency is exactly 2 cycles from input sample to tmds; throughput is one symbol per cycle with no stalls and no handshake.
- On rst_pix=1 at an edge:
  - Both pipeline stages load control-00 state.
  - cnt is set to 0.
  - tmds = 10'b1101010100 (0x354) from the next edge onward, and stays there for 2 cycles after rst_pix falls until real input propagates.
- Reset asserted mid-stream discards in-flight symbols; there is no partial output.
- de transitions are handled per cycle. The first data symbol after any control or island symbol always encodes with cnt=0.
- Simultaneous de=1 and island_in=1: de takes priority (video).

## Configuration
- TMDS_TERC4_EN defined: when staged de=0 and island_in=1, tmds is the TERC4 code for terc4_in, and cnt is forced to 0.
  - TERC4 codes, 0–F in order: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- TMDS_TERC4_EN undefined: island_in and terc4_in are ignored (lint-waived unused), and no TERC4 logic is synthesised.

## Structure
- Shared package tmds_pkg holds:
  - the 10-bit symbol typedef `tmds_sym_t`;
  - the four control-symbol constants;
  - the 16-entry TERC4 constant array;
  - the reset symbol constant.
- Sub-module tmds_balance implements stage 2 (disparity register and case A/B/C selection); the top level holds stage 1 and the control/TERC4 muxing.

## Test plan
- Reset: hold rst_pix=1 for 3 cycles, then release with de=0, ctrl=00 → tmds=0x354 on every cycle.
- Control codes: de=0, ctrl 01/10/11 → tmds 0x0AB/0x154/0x2AB exactly 2 cycles after each input.
- Disparity alternation: after a control symbol, de=1 with data_in=0x00 for 3 cycles → tmds 0x100, 0x3FF, 0x100; cnt −8, +2, −6.
- XNOR path: after a control symbol, de=1 with data_in=0xFF → tmds=0x200, cnt=−8.
- Mid-stream reset: random data with rst_pix pulsed for 1 cycle → tmds=0x354 the following cycle, then matches the reference-model stream restarting with cnt=0.
- TERC4 (with TMDS_TERC4_EN): de=0, island_in=1, terc4_in=0x0..0xF → table codes in order; the following de=1 data uses cnt=0.
